dm_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the single-port data memory (word array, combinational read, write on clk edge, DMsel/l_or_s command encoding). Requester 0 is the CPU MEM stage, requester 1 is the debug/DMA port. The block arbitrates round-robin, registers one command per access, drives the memory command bus for exactly one cycle, and returns registered read data plus a one-cycle ack. Misaligned or illegal requests are rejected with an error flag and never reach memory.

---
 rtl/dm_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dm_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of the single-port data memory.
// Define DM_ARB_STAT_EN to build the saturating grant/error statistics counters.
module dm_arbiter #(
  parameter int CNT_W    = 16,
  parameter bit RST_LAST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_req,
  input  logic             r0_we,
  input  logic [1:0]       r0_size,
  input  logic [31:0]      r0_addr,
  input  logic [31:0]      r0_wdata,
  input  logic [31:0]      r0_pc,
  output logic             r0_ack,
  output logic             r0_err,
  output logic [31:0]      r0_rdata,
  input  logic             r1_req,
  input  logic             r1_we,
  input  logic [1:0]       r1_size,
  input  logic [31:0]      r1_addr,
  input  logic [31:0]      r1_wdata,
  input  logic [31:0]      r1_pc,
  output logic             r1_ack,
  output logic             r1_err,
  output logic [31:0]      r1_rdata,
  output logic [1:0]       dm_sel,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wd,
  output logic [1:0]       dm_l_or_s,
  output logic [31:0]      dm_pc,
  input  logic [31:0]      dm_rd,
  output logic [CNT_W-1:0] stat_g0,
  output logic [CNT_W-1:0] stat_g1,
  output logic [CNT_W-1:0] stat_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  state_t      state;
  logic        last;
  logic        gnt_port;
  logic        gnt_err;
  logic        gnt_we;

  logic        req_any;
  logic        sel;
  logic        g_we;
  logic [1:0]  g_size;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [31:0] g_pc;
  logic        g_illegal;

  // Tie goes to the port not served last; a lone request wins outright.
  always_comb begin
    req_any   = r0_req | r1_req;
    sel       = (r0_req & r1_req) ? ~last : r1_req;
    g_we      = sel ? r1_we    : r0_we;
    g_size    = sel ? r1_size  : r0_size;
    g_addr    = sel ? r1_addr  : r0_addr;
    g_wdata   = sel ? r1_wdata : r0_wdata;
    g_pc      = sel ? r1_pc    : r0_pc;
    g_illegal = (g_size == 2'b11) ||
                (g_size == 2'b01 && g_addr[0]) ||
                (g_size == 2'b00 && g_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      last      <= RST_LAST;
      gnt_port  <= 1'b0;
      gnt_err   <= 1'b0;
      gnt_we    <= 1'b0;
      r0_ack    <= 1'b0;
      r0_err    <= 1'b0;
      r0_rdata  <= '0;
      r1_ack    <= 1'b0;
      r1_err    <= 1'b0;
      r1_rdata  <= '0;
      dm_sel    <= '0;
      dm_addr   <= '0;
      dm_wd     <= '0;
      dm_l_or_s <= '0;
      dm_pc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            last     <= sel;
            gnt_port <= sel;
            gnt_err  <= g_illegal;
            gnt_we   <= g_we;
            state    <= ACCESS;
            // Rejected requests keep the whole memory bus quiet.
            if (!g_illegal) begin
              dm_sel    <= g_size;
              dm_addr   <= g_addr;
              dm_wd     <= g_wdata;
              dm_pc     <= g_pc;
              dm_l_or_s <= g_we ? 2'b10 : 2'b01;
            end
          end
        end
        ACCESS: begin
          dm_sel    <= '0;
          dm_addr   <= '0;
          dm_wd     <= '0;
          dm_pc     <= '0;
          dm_l_or_s <= '0;
          if (gnt_port) begin
            r1_ack <= 1'b1;
            r1_err <= gnt_err;
            if (!gnt_err && !gnt_we) r1_rdata <= dm_rd;
          end else begin
            r0_ack <= 1'b1;
            r0_err <= gnt_err;
            if (!gnt_err && !gnt_we) r0_rdata <= dm_rd;
          end
          state <= ACK;
        end
        ACK: begin
          r0_ack <= 1'b0;
          r0_err <= 1'b0;
          r1_ack <= 1'b0;
          r1_err <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DM_ARB_STAT_EN
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] g0_q, g1_q, err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g0_q  <= '0;
      g1_q  <= '0;
      err_q <= '0;
    end else if (state == IDLE && req_any) begin
      if (!sel && g0_q != '1)     g0_q  <= g0_q + ONE;
      if (sel && g1_q != '1)      g1_q  <= g1_q + ONE;
      if (g_illegal && err_q != '1) err_q <= err_q + ONE;
    end
  end

  assign stat_g0  = g0_q;
  assign stat_g1  = g1_q;
  assign stat_err = err_q;
`else
  assign stat_g0  = '0;
  assign stat_g1  = '0;
  assign stat_err = '0;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a little-endian sign-extending memory model.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [1:0]  r0_size, r1_size;
  logic [31:0] r0_addr, r0_wdata, r0_pc, r1_addr, r1_wdata, r1_pc;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [1:0]  dm_sel, dm_l_or_s;
  logic [31:0] dm_addr, dm_wd, dm_pc, dm_rd;
  logic [15:0] stat_g0, stat_g1, stat_err;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_size(r0_size), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_pc(r0_pc), .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_size(r1_size), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_pc(r1_pc), .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .dm_sel(dm_sel), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_l_or_s(dm_l_or_s),
    .dm_pc(dm_pc), .dm_rd(dm_rd),
    .stat_g0(stat_g0), .stat_g1(stat_g1), .stat_err(stat_err)
  );

  // Memory model: combinational sign-extended read, byte-lane write on the edge.
  logic [31:0] mem [64] = '{default: 32'h0};
  logic [31:0] mw;
  logic [15:0] mh;
  logic [7:0]  mb;

  always_comb begin
    mw = mem[dm_addr[7:2]];
    mh = mw[{dm_addr[1], 4'b0000} +: 16];
    mb = mw[{dm_addr[1:0], 3'b000} +: 8];
    case (dm_sel)
      2'b01:   dm_rd = {{16{mh[15]}}, mh};
      2'b10:   dm_rd = {{24{mb[7]}}, mb};
      default: dm_rd = mw;
    endcase
  end

  always @(posedge clk) begin
    if (dm_l_or_s == 2'b10) begin
      case (dm_sel)
        2'b10:   mem[dm_addr[7:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_wd[7:0];
        2'b01:   mem[dm_addr[7:2]][{dm_addr[1], 4'b0000} +: 16] <= dm_wd[15:0];
        default: mem[dm_addr[7:2]] <= dm_wd;
      endcase
    end
  end

  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        obs[$];
  exp_t        e, o;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cmd_cnt, first_ack, stray_err = 0;
  logic [1:0]  cmd_val;
  logic [97:0] cmd_bus;

  function automatic exp_t mk(input logic p, input logic er, input logic [31:0] d);
    exp_t t;
    t.port = p; t.err = er; t.rdata = d;
    return t;
  endfunction

  task automatic drive(input logic p, input logic we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin
      r1_we = we; r1_size = size; r1_addr = addr; r1_wdata = wdata;
      r1_pc = addr + 32'h1000; r1_req = 1'b1;
    end else begin
      r0_we = we; r0_size = size; r0_addr = addr; r0_wdata = wdata;
      r0_pc = addr + 32'h1000; r0_req = 1'b1;
    end
  endtask

  // Observes ncyc falling edges, logging acks and memory commands; optionally
  // drops a port's request once it has been acked.
  task automatic collect(input int ncyc, input bit drop);
    cmd_cnt = 0; cmd_val = 2'b00; first_ack = -1; cmd_bus = '0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (dm_l_or_s != 2'b00) begin
        cmd_cnt++; cmd_val = dm_l_or_s; cmd_bus = {dm_sel, dm_addr, dm_wd, dm_pc};
      end
      if ((r0_err && !r0_ack) || (r1_err && !r1_ack)) stray_err++;
      if (r0_ack) begin
        obs.push_back(mk(1'b0, r0_err, r0_rdata));
        if (first_ack < 0) first_ack = c;
        if (drop) r0_req = 1'b0;
      end
      if (r1_ack) begin
        obs.push_back(mk(1'b1, r1_err, r1_rdata));
        if (first_ack < 0) first_ack = c;
        if (drop) r1_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({dm_sel, dm_addr, dm_wd, dm_l_or_s, dm_pc} !== '0) begin
      n_fail++; $display("FAIL reset_dm: got l_or_s %b addr %h, want all zero", dm_l_or_s, dm_addr);
    end
    n_chk++;
    if ({r0_ack, r0_err, r0_rdata, r1_ack, r1_err, r1_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_ports: got ack %b%b rdata %h %h, want zero", r0_ack, r1_ack, r0_rdata, r1_rdata);
    end
    n_chk++;
    if ({stat_g0, stat_g1, stat_err} !== '0) begin
      n_fail++; $display("FAIL reset_stat: got %0d %0d %0d, want 0 0 0", stat_g0, stat_g1, stat_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_store_load;
    obs.delete();
    sb.push_back(mk(1'b0, 1'b0, 32'h0));
    drive(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
    collect(4, 1'b1);
    n_chk++;
    if (cmd_cnt !== 1 || cmd_val !== 2'b10) begin
      n_fail++; $display("FAIL store_cmd: got %0d cycles of %b, want 1 cycle of 10", cmd_cnt, cmd_val);
    end
    n_chk++;
    if (cmd_bus !== {2'b00, 32'h10, 32'hDEADBEEF, 32'h1010}) begin
      n_fail++; $display("FAIL store_bus: got %h, want %h", cmd_bus, {2'b00, 32'h10, 32'hDEADBEEF, 32'h1010});
    end
    n_chk++;
    if (first_ack !== 2) begin
      n_fail++; $display("FAIL store_latency: got ack at cycle %0d, want 2", first_ack);
    end
    sb.push_back(mk(1'b0, 1'b0, 32'hDEADBEEF));
    drive(1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
    collect(4, 1'b1);
    n_chk++;
    if (cmd_cnt !== 1 || cmd_val !== 2'b01) begin
      n_fail++; $display("FAIL load_cmd: got %0d cycles of %b, want 1 cycle of 01", cmd_cnt, cmd_val);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_chk++;
      if (obs.size() == 0) begin
        n_fail++; $display("FAIL store_load_ack: got no ack, want port %0d", e.port);
      end else begin
        o = obs.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL store_load_ack: got p%0d err %0d %h, want p%0d err %0d %h",
                             o.port, o.err, o.rdata, e.port, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_byte_half;
    obs.delete();
    sb.push_back(mk(1'b0, 1'b0, 32'hDEADBEEF));
    drive(1'b0, 1'b1, 2'b00, 32'h20, 32'h80FF7F01);
    collect(4, 1'b1);
    sb.push_back(mk(1'b0, 1'b0, 32'hFFFFFF80));
    drive(1'b0, 1'b0, 2'b10, 32'h23, 32'h0);
    collect(4, 1'b1);
    sb.push_back(mk(1'b0, 1'b0, 32'h00007F01));
    drive(1'b0, 1'b0, 2'b01, 32'h20, 32'h0);
    collect(4, 1'b1);
    sb.push_back(mk(1'b0, 1'b0, 32'hFFFF80FF));
    drive(1'b0, 1'b0, 2'b01, 32'h22, 32'h0);
    collect(4, 1'b1);
    sb.push_back(mk(1'b0, 1'b0, 32'h0000007F));
    drive(1'b0, 1'b0, 2'b10, 32'h21, 32'h0);
    collect(4, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_chk++;
      if (obs.size() == 0) begin
        n_fail++; $display("FAIL byte_half: got no ack, want rdata %h", e.rdata);
      end else begin
        o = obs.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL byte_half: got p%0d err %0d %h, want p%0d err %0d %h",
                             o.port, o.err, o.rdata, e.port, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_contention;
    obs.delete();
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'h10, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1'b0, 1'b0, 32'hDEADBEEF));
      sb.push_back(mk(1'b1, 1'b0, 32'h80FF7F01));
    end
    collect(12, 1'b0);
    r0_req = 1'b0; r1_req = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_chk++;
      if (obs.size() == 0) begin
        n_fail++; $display("FAIL contention_order: got no ack, want port %0d", e.port);
      end else begin
        o = obs.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL contention_order: got p%0d err %0d %h, want p%0d err %0d %h",
                             o.port, o.err, o.rdata, e.port, e.err, e.rdata);
        end
      end
    end
    n_chk++;
    if (obs.size() != 0) begin
      n_fail++; $display("FAIL contention_extra: got %0d extra acks, want 0", obs.size());
    end
  endtask

  task automatic test_misaligned;
    obs.delete();
    sb.push_back(mk(1'b1, 1'b1, 32'h80FF7F01));
    drive(1'b1, 1'b0, 2'b00, 32'h22, 32'h0);
    collect(4, 1'b1);
    n_chk++;
    if (cmd_cnt !== 0) begin
      n_fail++; $display("FAIL misaligned_cmd: got %0d command cycles, want 0", cmd_cnt);
    end
    sb.push_back(mk(1'b0, 1'b1, 32'hDEADBEEF));
    drive(1'b0, 1'b0, 2'b01, 32'h21, 32'h0);
    collect(4, 1'b1);
    n_chk++;
    if (cmd_cnt !== 0) begin
      n_fail++; $display("FAIL odd_half_cmd: got %0d command cycles, want 0", cmd_cnt);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_chk++;
      if (obs.size() == 0) begin
        n_fail++; $display("FAIL misaligned_ack: got no ack, want port %0d", e.port);
      end else begin
        o = obs.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL misaligned_ack: got p%0d err %0d %h, want p%0d err %0d %h",
                             o.port, o.err, o.rdata, e.port, e.err, e.rdata);
        end
      end
    end
`ifdef DM_ARB_STAT_EN
    n_chk++;
    if (stat_err !== 16'd2) begin
      n_fail++; $display("FAIL misaligned_stat: got stat_err %0d, want 2", stat_err);
    end
`endif
  endtask

  task automatic test_reset_mid;
    obs.delete();
    drive(1'b0, 1'b1, 2'b00, 32'h30, 32'h12345678);
    @(negedge clk);
    n_chk++;
    if (dm_l_or_s !== 2'b10) begin
      n_fail++; $display("FAIL mid_access_cmd: got %b, want 10", dm_l_or_s);
    end
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if ({dm_l_or_s, dm_addr, dm_wd} !== '0) begin
      n_fail++; $display("FAIL mid_reset_clear: got l_or_s %b addr %h, want zero", dm_l_or_s, dm_addr);
    end
    r0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    collect(4, 1'b1);
    n_chk++;
    if (obs.size() != 0) begin
      n_fail++; $display("FAIL mid_reset_ack: got %0d acks, want 0", obs.size());
    end
    obs.delete();
    sb.push_back(mk(1'b0, 1'b0, 32'h0));
    drive(1'b0, 1'b0, 2'b00, 32'h30, 32'h0);
    collect(4, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_chk++;
      if (obs.size() == 0) begin
        n_fail++; $display("FAIL mid_reset_load: got no ack, want rdata %h", e.rdata);
      end else begin
        o = obs.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL mid_reset_load: got p%0d err %0d %h, want p%0d err %0d %h",
                             o.port, o.err, o.rdata, e.port, e.err, e.rdata);
        end
      end
    end
  endtask

  task automatic test_size11;
    obs.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(mk(1'b0, 1'b1, 32'h0));
    sb.push_back(mk(1'b1, 1'b0, 32'h0));
    drive(1'b0, 1'b0, 2'b11, 32'h44, 32'h0);
    drive(1'b1, 1'b1, 2'b00, 32'h40, 32'hCAFEF00D);
    collect(8, 1'b1);
    n_chk++;
    if (cmd_cnt !== 1 || cmd_val !== 2'b10) begin
      n_fail++; $display("FAIL size11_cmd: got %0d cycles of %b, want 1 cycle of 10", cmd_cnt, cmd_val);
    end
    sb.push_back(mk(1'b1, 1'b0, 32'hCAFEF00D));
    drive(1'b1, 1'b0, 2'b00, 32'h40, 32'h0);
    collect(4, 1'b1);
    while (sb.size() > 0) begin
      e = sb.pop_front(); n_chk++;
      if (obs.size() == 0) begin
        n_fail++; $display("FAIL size11_ack: got no ack, want port %0d", e.port);
      end else begin
        o = obs.pop_front();
        if (o !== e) begin
          n_fail++; $display("FAIL size11_ack: got p%0d err %0d %h, want p%0d err %0d %h",
                             o.port, o.err, o.rdata, e.port, e.err, e.rdata);
        end
      end
    end
    n_chk++;
    if (stray_err !== 0) begin
      n_fail++; $display("FAIL stray_err: got %0d err cycles without ack, want 0", stray_err);
    end
`ifdef DM_ARB_STAT_EN
    n_chk++;
    if ({stat_g0, stat_g1, stat_err} !== {16'd1, 16'd2, 16'd1}) begin
      n_fail++; $display("FAIL size11_stat: got %0d %0d %0d, want 1 2 1", stat_g0, stat_g1, stat_err);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    r0_req = 1'b0; r0_we = 1'b0; r0_size = 2'b00; r0_addr = '0; r0_wdata = '0; r0_pc = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_size = 2'b00; r1_addr = '0; r1_wdata = '0; r1_pc = '0;
    test_reset;
    test_store_load;
    test_byte_half;
    test_contention;
    test_misaligned;
    test_reset_mid;
    test_size11;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
